// File: rtl/a2d_sched.sv
`default_nettype none
// ============================================================================
// Module      : a2d_sched
// Description : Sequences A2D conversions over an SPI master. Each conversion
//               is a channel-select transaction followed by a read
//               transaction, separated by GAP_CYC idle clocks. The channel
//               pointer walks lft_ld(ch0) -> rght_ld(ch4) -> steer_pot(ch5)
//               -> batt(ch6) and wraps back to lft_ld.
//               Optional macro A2D_SCHED_SWEEP_EN: one accepted nxt converts
//               all four channels in pointer order. Undefined (the default):
//               one channel per nxt.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               nxt        - single-cycle conversion request
//               wrt        - single-cycle start strobe to the SPI master
//               cmd[15:0]  - SPI command word, stable from wrt to done
//               done       - SPI transaction-complete pulse
//               rd_data    - SPI received word, [11:0] is the result
//               lft_ld, rght_ld, steer_pot, batt [11:0] - latest results
//               busy       - conversion in progress
//               cnv_cmplt  - single-cycle conversion/sweep complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module a2d_sched #(
    parameter int unsigned GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        cnv_cmplt
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_sel      = 3'd1;
    localparam logic [2:0] c_st_wait_sel = 3'd2;
    localparam logic [2:0] c_st_gap      = 3'd3;
    localparam logic [2:0] c_st_rd       = 3'd4;
    localparam logic [2:0] c_st_wait_rd  = 3'd5;
    localparam logic [2:0] c_st_done     = 3'd6;

    localparam logic [3:0] c_gap_last = 4'(GAP_CYC - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [1:0]  r_ptr;
    logic [3:0]  r_gap_cnt;
    logic        r_gap_to_sel;
    logic        r_wrt;
    logic [15:0] r_cmd;
    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic [11:0] r_steer;
    logic [11:0] r_batt;

    logic        w_issue;
    logic        w_load;
    logic        w_ptr_adv;
    logic        w_more;
    logic        w_gap_last;
    logic [2:0]  w_ch;
    logic        w_unused_rd_hi;

    // Upper nibble of the received word carries no result bits.
    assign w_unused_rd_hi = ^rd_data[15:12];

`ifdef A2D_SCHED_SWEEP_EN
    // Keep going until the batt channel has been read.
    assign w_more = (r_ptr != 2'd3);
`else
    assign w_more = 1'b0;
`endif

    // Pointer slot to physical A2D channel number.
    always_comb begin
        w_ch = 3'd0;
        case (r_ptr)
            2'd0:    w_ch = 3'd0;
            2'd1:    w_ch = 3'd4;
            2'd2:    w_ch = 3'd5;
            default: w_ch = 3'd6;
        endcase
    end

    assign w_gap_last = (r_gap_cnt == c_gap_last);

    // wrt is registered: a transaction is "issued" one cycle before its
    // strobe appears. SEL issues straight away; the read (and, in sweep mode,
    // the next channel's select) is issued on the last GAP cycle so that
    // exactly GAP_CYC idle clocks separate the previous done from the strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_ptr_adv   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (nxt) begin
                    w_state_nxt = c_st_sel;
                end
            end
            c_st_sel: begin
                w_issue     = 1'b1;
                w_state_nxt = c_st_wait_sel;
            end
            c_st_wait_sel: begin
                if (done) begin
                    w_state_nxt = c_st_gap;
                end
            end
            c_st_gap: begin
                if (w_gap_last) begin
                    w_issue     = 1'b1;
                    w_state_nxt = r_gap_to_sel ? c_st_wait_sel : c_st_rd;
                end
            end
            c_st_rd: begin
                w_state_nxt = c_st_wait_rd;
            end
            c_st_wait_rd: begin
                if (done) begin
                    w_load = 1'b1;
                    if (w_more) begin
                        w_ptr_adv   = 1'b1;
                        w_state_nxt = c_st_gap;
                    end else begin
                        w_state_nxt = c_st_done;
                    end
                end
            end
            c_st_done: begin
                w_ptr_adv   = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= 2'd0;
            r_gap_cnt    <= 4'd0;
            r_gap_to_sel <= 1'b0;
            r_wrt        <= 1'b0;
            r_cmd        <= 16'h0000;
            r_lft        <= 12'h000;
            r_rght       <= 12'h000;
            r_steer      <= 12'h000;
            r_batt       <= 12'h000;
        end else begin
            r_wrt <= w_issue;
            if (w_issue) begin
                r_cmd <= {2'b00, w_ch, 11'h000};
            end

            if (r_state == c_st_gap) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= 4'd0;
            end

            // Remembers what the coming GAP leads into: a read after a
            // select, or the next channel's select after a sweep read.
            if (r_state == c_st_wait_sel) begin
                r_gap_to_sel <= 1'b0;
            end else if (r_state == c_st_wait_rd) begin
                r_gap_to_sel <= 1'b1;
            end

            if (w_load) begin
                case (r_ptr)
                    2'd0:    r_lft   <= rd_data[11:0];
                    2'd1:    r_rght  <= rd_data[11:0];
                    2'd2:    r_steer <= rd_data[11:0];
                    default: r_batt  <= rd_data[11:0];
                endcase
            end

            if (w_ptr_adv) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign wrt       = r_wrt;
    assign cmd       = r_cmd;
    assign lft_ld    = r_lft;
    assign rght_ld   = r_rght;
    assign steer_pot = r_steer;
    assign batt      = r_batt;
    assign busy      = (r_state != c_st_idle);
    assign cnv_cmplt = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 SHALL provide parameter GAP_CYC, default 2, meaning idle clocks between the channel-select transaction's done and the read transaction's wrt (range 1..15).
REQ-002 SHALL provide port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL provide port nxt  input  1  single-cycle request to start a conversion.
REQ-005 SHALL provide port wrt  output  1  single-cycle start strobe to the SPI master.
REQ-006 SHALL provide port cmd  output  16  SPI command word.
REQ-007 SHALL provide port done  input  1  SPI master transaction-complete pulse.
REQ-008 SHALL provide port rd_data  input  16  SPI master received word.
REQ-009 SHALL provide ports lft_ld, rght_ld, steer_pot, batt  output  12 each  latest conversion results.
REQ-010 SHALL provide port busy  output  1  high from the cycle after an accepted nxt until cnv_cmplt.
REQ-011 SHALL provide port cnv_cmplt  output  1  single-cycle pulse when a conversion or sweep finishes.

Function
REQ-012 SHALL use the channel pointer order lft_ld(ch0) -> rght_ld(ch4) -> steer_pot(ch5) -> batt(ch6), then wrap to lft_ld.
REQ-013 SHALL use the states IDLE, SEL, WAIT_SEL, GAP, RD, WAIT_RD and DONE.
REQ-014 SHALL accept nxt only in IDLE; in IDLE, nxt SHALL cause the transition to SEL on the next edge.
REQ-015 SHALL, in SEL, assert wrt for exactly one cycle with cmd = {2'b00, ch[2:0], 11'h000}, then go to WAIT_SEL.
REQ-016 SHALL hold cmd stable from wrt until the matching done.
REQ-017 SHALL, in WAIT_SEL, discard rd_data and go to GAP on done.
REQ-018 SHALL remain in GAP for exactly GAP_CYC cycles, then go to RD.
REQ-019 SHALL, in RD, assert wrt for one cycle with the same cmd, then go to WAIT_RD.
REQ-020 SHALL, on done in WAIT_RD, load rd_data[11:0] into the result register of the current channel, effective at the next edge.
REQ-021 SHALL leave rd_data[15:12] unused.
REQ-022 SHALL, in DONE, pulse cnv_cmplt for one cycle, advance the pointer with wrap, and return to IDLE.
REQ-023 SHALL give latency: nxt at cycle N -> wrt at N+2; done_rd at cycle E -> result visible and cnv_cmplt high at E+1.
REQ-024 SHALL ignore nxt while busy, with no queueing and no pointer change.
REQ-025 SHALL ignore done outside the WAIT states.
REQ-026 SHALL, when done and nxt coincide in the final WAIT_RD cycle, drop the nxt.
REQ-027 SHALL leave result registers not being converted unchanged.

Reset
REQ-028 SHALL, on rst high at a clock edge, go to IDLE and drive wrt=0, busy=0, cnv_cmplt=0, cmd=16'h0000.
REQ-029 SHALL, on reset, set the pointer to lft_ld and all four result registers to 12'h000.
REQ-030 SHALL, when rst is asserted mid-transaction, abort the conversion with no result update and no cnv_cmplt, and ignore any later stray done.
REQ-031 SHALL take priority for rst over nxt and done in the same cycle.

Configuration
REQ-032 SHALL, with macro A2D_SCHED_SWEEP_EN defined, convert all four channels in pointer order per accepted nxt.
REQ-033 SHALL, in sweep mode, keep busy high throughout and pulse cnv_cmplt once after the batt result loads.
REQ-034 SHALL, in sweep mode, insert GAP_CYC idle cycles between one channel's read done and the next channel's SEL wrt.
REQ-035 SHALL, in sweep mode, leave the pointer at lft_ld at the end.
REQ-036 SHALL, without A2D_SCHED_SWEEP_EN, convert exactly one channel per nxt per REQ-014..REQ-022.

Verification
REQ-037 SHALL cover: SPI model (done 10 cycles after wrt, returns 16'hF123) with nxt -> cmd 16'h0000 twice, lft_ld=12'h123, cnv_cmplt once, rght_ld/steer_pot/batt stay 0.
REQ-038 SHALL cover: 5 nxts returning 12'h190, 12'h12C, 12'h0C8, 12'h8FF, 12'h111 -> cmd channels 0,4,5,6,0 and final lft_ld=12'h111, rght_ld=12'h12C, steer_pot=12'h0C8, batt=12'h8FF.
REQ-039 SHALL cover: GAP_CYC=4 -> exactly 4 cycles from first done to second wrt, and nxt at N gives wrt at N+2.
REQ-040 SHALL cover: nxt pulsed during WAIT_SEL and again coincident with the final done -> both ignored, one cnv_cmplt, pointer advanced by one.
REQ-041 SHALL cover: rst asserted in GAP, then done injected -> no wrt, results all 0, pointer lft_ld, busy=0.
REQ-042 SHALL cover: A2D_SCHED_SWEEP_EN with one nxt -> 8 wrt pulses, cmd channels 0,0,4,4,5,5,6,6, a single cnv_cmplt, and all four registers loaded.
